// File: rtl/sound_pkg.sv
// Shared state encoding and default timing for the sound player and its bench.
// Latency/backpressure: n/a (declarations only).
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY1 = 2'd1,
    PLAY2 = 2'd2
  } state_t;

  // 50 MHz clock: 1 kHz brick tone, 500 Hz bounce tone, 0.1 s per tone
  localparam int TONE1_HALF_DEF = 25000;
  localparam int TONE2_HALF_DEF = 50000;
  localparam int DURATION_DEF   = 5000000;
  localparam int CNT_W_DEF      = 23;

endpackage

// File: rtl/square_wave_gen.sv
// Half-period counter and phase bit; clear starts a high half-period, stop parks low.
// Latency: phase_nxt is the value phase takes at the next edge; no backpressure.
module square_wave_gen #(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_last,
  output logic             phase_nxt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] half_cnt_nxt;
  logic             phase;

  always_comb begin
    half_cnt_nxt = half_cnt;
    phase_nxt    = phase;
    if (clear) begin
      half_cnt_nxt = '0;
      phase_nxt    = 1'b1;
    end else if (stop) begin
      half_cnt_nxt = '0;
      phase_nxt    = 1'b0;
    end else if (run) begin
      if (half_cnt == half_last) begin
        half_cnt_nxt = '0;
        phase_nxt    = ~phase;
      end else begin
        half_cnt_nxt = half_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      half_cnt <= half_cnt_nxt;
      phase    <= phase_nxt;
    end
  end

endmodule

// File: rtl/sound_player.sv
// Single-voice square-wave player: rising edge on a trigger starts a fixed tone, brick beats bounce.
// Latency: tone starts one cycle after the trigger is sampled; no backpressure, triggers never stall.
module sound_player
  import sound_pkg::*;
#(
  parameter int TONE1_HALF = TONE1_HALF_DEF,
  parameter int TONE2_HALF = TONE2_HALF_DEF,
  parameter int DURATION   = DURATION_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_sound1,
  input  logic       play_sound2,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] tone_id
);

  localparam logic [CNT_W-1:0] T1_LAST  = CNT_W'(TONE1_HALF - 1);
  localparam logic [CNT_W-1:0] T2_LAST  = CNT_W'(TONE2_HALF - 1);
  localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DURATION - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             prev1;
  logic             prev2;
  logic             rise1;
  logic             rise2;
  logic             start;
  logic             expire;
  logic             playing;
  logic             phase_nxt;
  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] dur_nxt;
  logic [CNT_W-1:0] half_last;

  assign rise1     = play_sound1 & ~prev1;
  assign rise2     = play_sound2 & ~prev2;
  assign playing   = (state != IDLE);
  assign half_last = (state == PLAY1) ? T1_LAST : T2_LAST;
  assign tone_id   = state;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (rise1) begin
          state_nxt = PLAY1;
          start     = 1'b1;
        end else if (rise2) begin
          state_nxt = PLAY2;
          start     = 1'b1;
        end
      end
      PLAY1: begin
        if (rise1) start = 1'b1;
      end
      PLAY2: begin
        if (rise1) begin
          state_nxt = PLAY1;
          start     = 1'b1;
        end else if (rise2) begin
          start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A restart landing on the last tone cycle keeps the tone going
    if (playing && !start && dur_cnt == DUR_LAST) begin
      state_nxt = IDLE;
      expire    = 1'b1;
    end
  end

  always_comb begin
    dur_nxt = dur_cnt;
    if (start || expire) dur_nxt = '0;
    else if (playing)    dur_nxt = dur_cnt + CNT_ONE;
  end

  square_wave_gen #(
    .CNT_W(CNT_W)
  ) u_wave (
    .clk      (clk),
    .reset    (reset),
    .run      (playing),
    .clear    (start),
    .stop     (expire),
    .half_last(half_last),
    .phase_nxt(phase_nxt)
  );

  // Edge registers come out of reset high so a held trigger cannot fire on release
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dur_cnt <= '0;
      prev1   <= 1'b1;
      prev2   <= 1'b1;
      speaker <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      dur_cnt <= dur_nxt;
      prev1   <= play_sound1;
      prev2   <= play_sound2;
      speaker <= phase_nxt & ~mute;
      busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player with short tones; expected outputs come from per-record tone segments.
module tb_sound_player;

  localparam int T1  = 4;
  localparam int T2  = 6;
  localparam int DUR = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_sound1;
  logic       play_sound2;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] tone_id;

  always #5 clk = ~clk;

  sound_player #(
    .TONE1_HALF(T1),
    .TONE2_HALF(T2),
    .DURATION  (DUR),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_sound1(play_sound1),
    .play_sound2(play_sound2),
    .mute       (mute),
    .speaker    (speaker),
    .busy       (busy),
    .tone_id    (tone_id)
  );

  typedef struct {
    logic       spk;
    logic       bsy;
    logic [1:0] id;
    int         rec;
    int         cyc;
  } exp_t;

  // Stimulus windows in cycle c (input sampled at edge c) plus up to two expected tone segments [s,e)
  typedef struct {
    int p1_s; int p1_l; int p1b;
    int p2_s; int p2_l;
    int mute_s; int mute_l;
    int rst_at; int win;
    int a_id; int a_s; int a_e;
    int b_id; int b_s; int b_e;
  } vec_t;

  vec_t vecs[7];
  exp_t sbq[$];
  exp_t got;
  int   total = 0;
  int   bad   = 0;

  function automatic logic in_win(int c, int s, int l);
    return (c >= s) && (c < s + l);
  endfunction

  function automatic exp_t model(vec_t v, int c, int rec, logic mute_c);
    exp_t e;
    int id = 0;
    int s = 0;
    int half;
    if (v.a_id != 0 && c >= v.a_s && c < v.a_e) begin id = v.a_id; s = v.a_s; end
    if (v.b_id != 0 && c >= v.b_s && c < v.b_e) begin id = v.b_id; s = v.b_s; end
    half  = (id == 1) ? T1 : T2;
    e.id  = 2'(id);
    e.bsy = (id != 0);
    e.spk = (id != 0) && (((c - s) / half) % 2 == 0) && !mute_c;
    e.rec = rec;
    e.cyc = c;
    return e;
  endfunction

  task automatic drive(input logic r, input logic p1, input logic p2, input logic m, input exp_t e);
    @(negedge clk);
    reset       = r;
    play_sound1 = p1;
    play_sound2 = p2;
    mute        = m;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      total++;
      if (speaker !== got.spk || busy !== got.bsy || tone_id !== got.id) begin
        bad++;
        $display("FAIL rec%0d cyc%0d: got spk=%b busy=%b id=%0d, want spk=%b busy=%b id=%0d",
                 got.rec, got.cyc, speaker, busy, tone_id, got.spk, got.bsy, got.id);
      end
    end
  end

  initial begin
    exp_t idle_e;
    reset       = 1'b1;
    play_sound1 = 1'b0;
    play_sound2 = 1'b0;
    mute        = 1'b0;

    //          p1_s p1_l p1b p2_s p2_l mu_s mu_l rst win  a_id a_s a_e  b_id b_s b_e
    vecs[0] = '{0,   1,   -1, 0,   0,   0,   0,   -1, 50,  1,   0,  40,  0,   0,  0};  // brick pulse
    vecs[1] = '{0,   0,   -1, 0,   100, 0,   0,   -1, 110, 2,   0,  40,  0,   0,  0};  // bounce held
    vecs[2] = '{11,  1,   -1, 0,   1,   0,   0,   -1, 60,  2,   0,  11,  1,   11, 51}; // brick preempts
    vecs[3] = '{0,   1,   -1, 11,  1,   0,   0,   -1, 50,  1,   0,  40,  0,   0,  0};  // bounce ignored
    vecs[4] = '{0,   1,   40, 0,   1,   0,   0,   -1, 90,  1,   0,  40,  1,   40, 80}; // both + restart at expiry
    vecs[5] = '{0,   50,  -1, 0,   0,   0,   0,   21, 60,  1,   0,  21,  0,   0,  0};  // reset mid-tone, held
    vecs[6] = '{0,   1,   -1, 0,   0,   10,  15,  -1, 50,  1,   0,  40,  0,   0,  0};  // mute mid-tone

    idle_e = '{1'b0, 1'b0, 2'd0, -1, 0};
    for (int i = 0; i < 3; i++) begin
      idle_e.cyc = i;
      drive(1'b1, 1'b0, 1'b0, 1'b0, idle_e);
    end

    for (int r = 0; r < 7; r++) begin
      for (int g = 0; g < 5; g++) begin
        idle_e.rec = r;
        idle_e.cyc = g - 5;
        drive(1'b0, 1'b0, 1'b0, 1'b0, idle_e);
      end
      for (int c = 0; c < vecs[r].win; c++) begin
        logic p1, p2, m, rs;
        p1 = in_win(c, vecs[r].p1_s, vecs[r].p1_l) || (c == vecs[r].p1b);
        p2 = in_win(c, vecs[r].p2_s, vecs[r].p2_l);
        m  = in_win(c, vecs[r].mute_s, vecs[r].mute_l);
        rs = (c == vecs[r].rst_at);
        drive(rs, p1, p2, m, model(vecs[r], c, r, m));
      end
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, idle_e);
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_player.md
Name: sound_player

Overview:
- Consumes the ball stage's two sound triggers: `play_sound1` (brick hit) and `play_sound2` (paddle/floor bounce).
- Drives a 1-bit square-wave speaker pin: a fixed-pitch tone of fixed duration per trigger.
- Single-voice player. The brick tone has priority over the bounce tone.
- Sits between the ball stage and the board speaker/buzzer pin.

Parameters:
- TONE1_HALF, 25000, clk cycles per half-period of brick tone (1 kHz at 50 MHz)
- TONE2_HALF, 50000, clk cycles per half-period of bounce tone (500 Hz at 50 MHz)
- DURATION, 5000000, clk cycles a tone plays (0.1 s at 50 MHz)
- CNT_W, 23, width of all internal counters; must hold DURATION-1 and both HALF-1 values

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- play_sound1  input  1  brick-hit trigger level, synchronous to clk
- play_sound2  input  1  bounce trigger level, synchronous to clk
- mute  input  1  when 1, speaker forced 0; FSM and counters keep running
- speaker  output  1  square-wave audio out
- busy  output  1  1 while a tone is playing
- tone_id  output  2  0 = idle, 1 = brick tone, 2 = bounce tone

Behaviour:
- Reset, synchronous, highest priority:
  - state = IDLE; speaker = 0, busy = 0, tone_id = 0.
  - All counters = 0.
  - Edge registers prev1 and prev2 = 1, so a trigger held high through reset does not fire on release.
- Edge detect:
  - rise1 = play_sound1 & ~prev1; rise2 = play_sound2 & ~prev2.
  - prev registers update every cycle.
  - Only rising edges trigger; a held level plays once.
- States: IDLE, PLAY1, PLAY2. Encoding: IDLE = 0, PLAY1 = 1, PLAY2 = 2; `tone_id` equals the state encoding.
- Start rule: at the clock edge where rise1 or rise2 is seen:
  - State enters PLAY1 (rise1) or PLAY2 (rise2 only) at that same edge.
  - half_cnt = 0, dur_cnt = 0, phase = 1.
  - Speaker is high starting the following cycle, i.e. one cycle of latency from trigger sample to tone.
- Transitions and priority:
  - IDLE: rise1 -> PLAY1; else rise2 -> PLAY2. Simultaneous rise1 and rise2 -> PLAY1.
  - PLAY1: rise1 restarts PLAY1 (counters cleared, phase = 1). rise2 is ignored.
  - PLAY2: rise1 preempts -> PLAY1 with restart. rise2 restarts PLAY2.
  - Any PLAY state with no restart: when dur_cnt == DURATION-1 -> IDLE, phase = 0.
  - A restart on the same cycle as expiry wins over expiry.
- Tone generation in a PLAY state:
  - half_cnt increments each cycle.
  - When half_cnt == HALF-1 (HALF = TONE1_HALF or TONE2_HALF per state), half_cnt wraps to 0 and phase toggles.
  - Result: high for HALF cycles, then low for HALF cycles.
- Duration:
  - dur_cnt increments each cycle in a PLAY state.
  - Tone lasts exactly DURATION cycles (busy = 1 for DURATION cycles).
- Outputs, all registered:
  - speaker = phase & ~mute.
  - busy = (state != IDLE).
- Arithmetic:
  - Unsigned counters of CNT_W bits; compare with ==.
  - A counter never passes its terminal value, so there is no wrap beyond it.
- Boundary: mute toggling mid-tone affects only speaker, never timing.
- Reset mid-tone: next cycle is IDLE with speaker 0, regardless of trigger levels.

Decomposition:
- Shared package sound_pkg holds:
  - state encoding constants (IDLE/PLAY1/PLAY2);
  - default TONE1_HALF, TONE2_HALF, DURATION, CNT_W, so the top-level and the bench share the values.
- One natural sub-module: square_wave_gen.
  - Inputs: clk, clear, half-period select value.
  - Outputs: phase; contains half_cnt.
- The FSM, edge detect and dur_cnt stay in sound_player.

Test Plan (bench overrides TONE1_HALF = 4, TONE2_HALF = 6, DURATION = 40):
- Pulse play_sound1 for 1 cycle after reset:
  - busy = 1 and tone_id = 1 for exactly 40 cycles.
  - speaker pattern is 4 high / 4 low, repeated 5 times, then 0.
- Hold play_sound2 high for 100 cycles:
  - exactly one 40-cycle tone, 6 high / 6 low, tone_id = 2;
  - no retrigger while held; idle afterwards.
- Start play_sound2, then pulse play_sound1 at cycle 10 of the tone:
  - tone_id switches to 1 next cycle; speaker restarts high at 4-cycle half-period;
  - busy stays high 40 cycles from the preempt.
- Start play_sound1, then pulse play_sound2 at cycle 10:
  - ignored; tone_id stays 1; tone ends 40 cycles after the first trigger.
- Rising edges on both inputs in the same cycle:
  - PLAY1, tone_id = 1.
  - Re-pulse play_sound1 at cycle 39 (expiry cycle): tone restarts, busy continuous for 40 more cycles.
- Assert reset at cycle 20 of a tone while play_sound1 is held high:
  - speaker = 0, busy = 0 next cycle;
  - no new tone after reset release until play_sound1 falls and rises again.
  - Separately, mute = 1 mid-tone: speaker = 0, but busy still drops exactly at cycle 40.
